// File: rtl/aes_round_stage_param.sv
// aes_round_stage_param
//   Two-entry (main + skid) pipeline stage applying one AES round per lane.
//   The round result is combinational from the main register, so with the
//   downstream always ready a beat appears one cycle after it is accepted and
//   one beat per cycle flows through. Key schedule, phase tag, new-instance
//   flag and sideband ride along with their beat untouched.
//
// Parameters
//   NUM_LANES  number of independent 128-bit AES state lanes
//   KEY_BITS   key schedule width: 1408, 1664 or 1920 (NR = 10, 12, 14)
//   SIDE_BITS  opaque sideband width
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   i_valid/o_ready   upstream handshake (o_ready is registered)
//   i_flush           synchronous discard of every held beat
//   i_state           lane states, lane 0 at the MSB end
//   i_round           4-bit round index per lane, lane 0 at the MSB end
//   i_lane_en         lane enable, bit n = lane n
//   i_key_schedule    round keys, key k at offset k*128 from the MSB end
//   i_phase, i_new_instance, i_side   carried with the beat
//   o_valid/i_ready   downstream handshake
//   o_state, o_round  processed lane states and next round index
//   o_lane_err        round index beyond NR on an enabled lane, bit n = lane n
//   o_key_schedule, o_phase, o_new_instance, o_side   carried fields
//   o_occupancy       number of held beats (0..2)

module aes_round_stage_param #(
  parameter int NUM_LANES = 3,
  parameter int KEY_BITS  = 1408,
  parameter int SIDE_BITS = 516
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_flush,
  input  logic [NUM_LANES*128-1:0] i_state,
  input  logic [NUM_LANES*4-1:0]   i_round,
  input  logic [NUM_LANES-1:0]     i_lane_en,
  input  logic [KEY_BITS-1:0]      i_key_schedule,
  input  logic [2:0]               i_phase,
  input  logic                     i_new_instance,
  input  logic [SIDE_BITS-1:0]     i_side,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [NUM_LANES*128-1:0] o_state,
  output logic [NUM_LANES*4-1:0]   o_round,
  output logic [NUM_LANES-1:0]     o_lane_err,
  output logic [KEY_BITS-1:0]      o_key_schedule,
  output logic [2:0]               o_phase,
  output logic                     o_new_instance,
  output logic [SIDE_BITS-1:0]     o_side,
  output logic [1:0]               o_occupancy
);

  localparam int NR = (KEY_BITS == 1408) ? 10 :
                      (KEY_BITS == 1664) ? 12 :
                      (KEY_BITS == 1920) ? 14 : 0;
  localparam logic [3:0] NR_L = 4'(NR);

  if (NR == 0) begin : g_bad_key_bits
    $error("aes_round_stage_param: KEY_BITS must be 1408, 1664 or 1920");
  end

  localparam int STATE_W = NUM_LANES * 128;
  localparam int ROUND_W = NUM_LANES * 4;
  localparam int BEAT_W  = STATE_W + ROUND_W + NUM_LANES + KEY_BITS + 3 + 1 + SIDE_BITS;

  // FIPS-197 S-box, entry 0 at the MSB end
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Byte i of the state is bits [127-8i -: 8]; byte 4c+r is row r, column c.
  function automatic logic [127:0] round_fn(input logic [127:0] st,
                                            input logic [127:0] rk,
                                            input logic         do_sub,
                                            input logic         do_mix);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) s[i] = st[127-8*i -: 8];
    if (do_sub) begin
      for (int i = 0; i < 16; i++) s[i] = SBOX[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[4*c+r] = s[4*((c+r)%4)+r];
      for (int i = 0; i < 16; i++) s[i] = t[i];
      if (do_mix) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c];
          a1 = s[4*c+1];
          a2 = s[4*c+2];
          a3 = s[4*c+3];
          s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i] ^ rk[127-8*i -: 8];
    return res;
  endfunction

  // ---------------------------------------------------------------------
  // Main / skid control
  // ---------------------------------------------------------------------
  logic              m_valid, s_valid, ready_q;
  logic              m_valid_nxt, s_valid_nxt;
  logic              accept, m_free;
  logic              load_m_from_s, load_m_from_in, load_s;
  logic [BEAT_W-1:0] in_beat, m_beat, s_beat;

  assign in_beat = {i_state, i_round, i_lane_en, i_key_schedule,
                    i_phase, i_new_instance, i_side};

  // ready_q always mirrors "S empty"; flush also blocks the offered beat.
  assign accept = i_valid & ready_q & ~i_flush;
  // M can take a new beat if it is empty or handing its beat downstream.
  assign m_free = ~m_valid | i_ready;

  assign load_m_from_s  = ~i_flush & m_free & s_valid;
  assign load_m_from_in = m_free & ~s_valid & accept;
  assign load_s         = accept & (s_valid | ~m_free);

  always_comb begin
    m_valid_nxt = m_valid;
    s_valid_nxt = s_valid;
    if (i_flush) begin
      m_valid_nxt = 1'b0;
      s_valid_nxt = 1'b0;
    end else if (m_free) begin
      m_valid_nxt = s_valid | accept;
      s_valid_nxt = s_valid & accept;
    end else begin
      s_valid_nxt = s_valid | accept;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid <= 1'b0;
      s_valid <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      m_valid <= m_valid_nxt;
      s_valid <= s_valid_nxt;
      ready_q <= ~s_valid_nxt;
    end
  end

  // Payload registers carry no reset; their content is qualified by m_valid.
  always_ff @(posedge clk) begin
    if (load_m_from_s)
      m_beat <= s_beat;
    else if (load_m_from_in)
      m_beat <= in_beat;
    if (load_s)
      s_beat <= in_beat;
  end

  assign o_valid     = m_valid;
  assign o_ready     = ready_q;
  assign o_occupancy = {m_valid & s_valid, m_valid ^ s_valid};

  // ---------------------------------------------------------------------
  // Round datapath from M
  // ---------------------------------------------------------------------
  logic [STATE_W-1:0]   m_state;
  logic [ROUND_W-1:0]   m_round;
  logic [NUM_LANES-1:0] m_lane_en;
  logic [KEY_BITS-1:0]  m_key;

  assign {m_state, m_round, m_lane_en, m_key, o_phase, o_new_instance, o_side} = m_beat;
  assign o_key_schedule = m_key;

  // Sixteen slots so any 4-bit round index selects safely; slots past NR
  // are never used because such lanes take the error path.
  logic [127:0] keys [16];
  for (genvar k = 0; k < 16; k++) begin : g_key
    if (k <= NR) begin : g_used
      assign keys[k] = m_key[KEY_BITS-1-128*k -: 128];
    end else begin : g_unused
      assign keys[k] = '0;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    localparam int SB = STATE_W - 1 - 128*l;
    localparam int RB = ROUND_W - 1 - 4*l;
    logic [127:0] st_in, st_rnd, st_out;
    logic [3:0]   r, r_out;
    logic         err;

    assign st_in  = m_state[SB -: 128];
    assign r      = m_round[RB -: 4];
    assign st_rnd = round_fn(st_in, keys[r], r != 4'd0, r != NR_L);

    always_comb begin
      st_out = st_in;
      r_out  = r;
      err    = 1'b0;
      if (m_lane_en[l]) begin
        if (r > NR_L) begin
          err = 1'b1;
        end else begin
          st_out = st_rnd;
          r_out  = r + 4'd1;
        end
      end
    end

    assign o_state[SB -: 128] = st_out;
    assign o_round[RB -: 4]   = r_out;
    assign o_lane_err[l]      = err & m_valid;
  end

endmodule

// File: tb/tb_aes_round_stage_param.sv
module tb_aes_round_stage_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic i_valid = 0, o_ready, i_flush = 0, i_new_instance = 0, o_valid, i_ready = 1, o_new_instance;
  logic [383:0] i_state = '0, o_state;
  logic [11:0] i_round = '0, o_round;
  logic [2:0] i_lane_en = '0, o_lane_err, i_phase = '0, o_phase;
  logic [1407:0] i_key_schedule = '0, o_key_schedule;
  logic [515:0] i_side = '0, o_side;
  logic [1:0] o_occupancy;

  logic d_i_valid = 0, d_o_ready, d_i_flush = 0, d_i_ni = 0, d_o_valid, d_i_ready = 1, d_o_ni;
  logic [383:0] d_i_state = '0, d_o_state;
  logic [11:0] d_i_round = '0, d_o_round;
  logic [2:0] d_i_en = '0, d_o_err, d_i_phase = '0, d_o_phase;
  logic [1919:0] d_i_key = '0, d_o_key;
  logic [515:0] d_i_side = '0, d_o_side;
  logic [1:0] d_o_occ;

  aes_round_stage_param dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready), .i_flush(i_flush),
    .i_state(i_state), .i_round(i_round), .i_lane_en(i_lane_en),
    .i_key_schedule(i_key_schedule), .i_phase(i_phase), .i_new_instance(i_new_instance),
    .i_side(i_side), .o_valid(o_valid), .i_ready(i_ready), .o_state(o_state),
    .o_round(o_round), .o_lane_err(o_lane_err), .o_key_schedule(o_key_schedule),
    .o_phase(o_phase), .o_new_instance(o_new_instance), .o_side(o_side),
    .o_occupancy(o_occupancy));

  aes_round_stage_param #(.NUM_LANES(3), .KEY_BITS(1920), .SIDE_BITS(516)) dut14 (
    .clk(clk), .rst(rst), .i_valid(d_i_valid), .o_ready(d_o_ready), .i_flush(d_i_flush),
    .i_state(d_i_state), .i_round(d_i_round), .i_lane_en(d_i_en),
    .i_key_schedule(d_i_key), .i_phase(d_i_phase), .i_new_instance(d_i_ni),
    .i_side(d_i_side), .o_valid(d_o_valid), .i_ready(d_i_ready), .o_state(d_o_state),
    .o_round(d_o_round), .o_lane_err(d_o_err), .o_key_schedule(d_o_key),
    .o_phase(d_o_phase), .o_new_instance(d_o_ni), .o_side(d_o_side),
    .o_occupancy(d_o_occ));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [383:0]  state;
    logic [11:0]   round;
    logic [2:0]    en;
    logic [1407:0] key;
    logic [2:0]    phase;
    logic          ni;
    logic [515:0]  side;
  } beat_t;

  // ---------------- reference model ----------------
  logic [7:0] sbox_m [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse then affine map.
  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = 8'h63 ^ inv;
      for (int k = 1; k <= 4; k++) s = s ^ 8'((inv << k) | (inv >> (8 - k)));
      sbox_m[x] = s;
    end
  endtask

  function automatic logic [127:0] ref_round(input logic [127:0] st, input logic [127:0] rk,
                                             input int r, input int nr);
    logic [7:0] g [4][4];
    logic [7:0] tmp [4];
    logic [7:0] coef [4];
    logic [7:0] acc;
    logic [127:0] res;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) g[w][c] = st[127-8*(4*c+w) -: 8];
    if (r > 0) begin
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) g[w][c] = sbox_m[g[w][c]];
      for (int w = 0; w < 4; w++) begin
        for (int c = 0; c < 4; c++) tmp[c] = g[w][(c+w)%4];
        for (int c = 0; c < 4; c++) g[w][c] = tmp[c];
      end
      if (r < nr) begin
        for (int c = 0; c < 4; c++) begin
          for (int w = 0; w < 4; w++) tmp[w] = g[w][c];
          for (int w = 0; w < 4; w++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j-w+4)%4], tmp[j]);
            g[w][c] = acc;
          end
        end
      end
    end
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++)
        res[127-8*(4*c+w) -: 8] = g[w][c] ^ rk[127-8*(4*c+w) -: 8];
    return res;
  endfunction

  function automatic logic [1407:0] expand128(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0] rc;
    logic [1407:0] ks;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]] ^ rc, sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) ks[1407-32*i -: 32] = w[i];
    return ks;
  endfunction

  task automatic exp_beat(input logic [383:0] st, input logic [11:0] rd, input logic [2:0] en,
                          input logic [1919:0] ks, input int kb, input int nr,
                          output logic [383:0] est, output logic [11:0] erd, output logic [2:0] eerr);
    logic [127:0] sl;
    int ri;
    for (int l = 0; l < 3; l++) begin
      sl = st[383-128*l -: 128];
      ri = int'(rd[11-4*l -: 4]);
      est[383-128*l -: 128] = sl;
      erd[11-4*l -: 4] = rd[11-4*l -: 4];
      eerr[l] = 1'b0;
      if (en[l]) begin
        if (ri > nr) eerr[l] = 1'b1;
        else begin
          est[383-128*l -: 128] = ref_round(sl, ks[kb-1-128*ri -: 128], ri, nr);
          erd[11-4*l -: 4] = 4'(ri + 1);
        end
      end
    end
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  task automatic rand_beat(output beat_t b);
    logic [543:0] tmp;
    for (int i = 0; i < 12; i++) b.state[32*i +: 32] = $urandom;
    for (int l = 0; l < 3; l++) b.round[4*l +: 4] = 4'($urandom_range(0, 15));
    for (int l = 0; l < 3; l++) b.en[l] = ($urandom_range(0, 9) < 8);
    for (int i = 0; i < 44; i++) b.key[32*i +: 32] = $urandom;
    b.phase = 3'($urandom_range(0, 7));
    b.ni = 1'($urandom_range(0, 1));
    for (int i = 0; i < 17; i++) tmp[32*i +: 32] = $urandom;
    b.side = tmp[515:0];
  endtask

  task automatic drive(input beat_t b, input logic v);
    i_valid = v; i_state = b.state; i_round = b.round; i_lane_en = b.en;
    i_key_schedule = b.key; i_phase = b.phase; i_new_instance = b.ni; i_side = b.side;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; i_valid = 0; i_flush = 0; i_ready = 1; d_i_valid = 0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", o_ready); end
    checks++; if (o_occupancy !== 2'd0) begin errors++; $display("FAIL rst_occ got %0d exp 0", o_occupancy); end
    checks++; if (o_lane_err !== 3'b000) begin errors++; $display("FAIL rst_err got %b exp 000", o_lane_err); end
    rst = 1'b0;
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rel_valid got %b exp 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rel_ready got %b exp 1", o_ready); end
    checks++; if (o_occupancy !== 2'd0) begin errors++; $display("FAIL rel_occ got %0d exp 0", o_occupancy); end
    checks++; if (o_lane_err !== 3'b000) begin errors++; $display("FAIL rel_err got %b exp 000", o_lane_err); end
  endtask

  task automatic test_fips();
    beat_t b;
    logic [383:0] est; logic [11:0] erd; logic [2:0] eerr;
    logic [127:0] vin [2];
    logic [127:0] vout [2];
    int vr [2];
    vin[0] = 128'h193de3bea0f4e22b9ac68d2ae9f84808; vout[0] = 128'ha49c7ff2689f352b6b5bea43026a5049; vr[0] = 1;
    vin[1] = 128'heb40f21e592e38848ba113e71bc342d2; vout[1] = 128'h3925841d02dc09fbdc118597196a0b32; vr[1] = 10;
    apply_reset();
    for (int t = 0; t < 2; t++) begin
      rand_beat(b);
      b.key = expand128(128'h2b7e151628aed2a6abf7158809cf4f3c);
      b.state[383:256] = vin[t];
      b.round[11:8] = 4'(vr[t]);
      b.round[7:4] = 4'($urandom_range(0, 10));
      b.round[3:0] = 4'($urandom_range(0, 10));
      b.en = 3'b111;
      drive(b, 1'b1);
      tick();
      i_valid = 1'b0;
      exp_beat(b.state, b.round, b.en, {512'b0, b.key}, 1408, 10, est, erd, eerr);
      checks++; if (o_valid !== 1'b1) begin errors++; $display("FAIL fips%0d_valid got %b exp 1", t, o_valid); end
      checks++; if (o_state[383:256] !== vout[t]) begin errors++; $display("FAIL fips%0d_state got %h exp %h", t, o_state[383:256], vout[t]); end
      checks++; if (o_round[11:8] !== 4'(vr[t] + 1)) begin errors++; $display("FAIL fips%0d_round got %0d exp %0d", t, o_round[11:8], vr[t] + 1); end
      checks++; if (o_state !== est) begin errors++; $display("FAIL fips%0d_lanes got %h exp %h", t, o_state, est); end
      checks++; if (o_lane_err !== 3'b000) begin errors++; $display("FAIL fips%0d_err got %b exp 000", t, o_lane_err); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    beat_t b;
    logic [383:0] est; logic [11:0] erd; logic [2:0] eerr;
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      rand_beat(b);
      drive(b, 1'b1);
      tick();
      exp_beat(b.state, b.round, b.en, {512'b0, b.key}, 1408, 10, est, erd, eerr);
      checks++; if (o_valid !== 1'b1 || o_occupancy !== 2'd1 || o_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_flow beat %0d got v%b r%b occ%0d exp v1 r1 occ1", i, o_valid, o_ready, o_occupancy); end
      checks++; if (o_state !== est) begin errors++; $display("FAIL b2b_state beat %0d got %h exp %h", i, o_state, est); end
      checks++; if (o_round !== erd || o_lane_err !== eerr) begin
        errors++; $display("FAIL b2b_round beat %0d got %h/%b exp %h/%b", i, o_round, o_lane_err, erd, eerr); end
      checks++; if (o_side !== b.side) begin errors++; $display("FAIL b2b_side beat %0d got %h exp %h", i, o_side, b.side); end
    end
    i_valid = 1'b0;
    tick();
    checks++; if (o_valid !== 1'b0 || o_occupancy !== 2'd0) begin
      errors++; $display("FAIL b2b_empty got v%b occ%0d exp v0 occ0", o_valid, o_occupancy); end
  endtask

  task automatic test_backpressure();
    beat_t b0, b1, b2;
    logic [383:0] est; logic [11:0] erd; logic [2:0] eerr;
    apply_reset();
    rand_beat(b0); rand_beat(b1); rand_beat(b2);
    i_ready = 1'b0;
    drive(b0, 1'b1); tick();
    drive(b1, 1'b1); tick();
    checks++; if (o_ready !== 1'b0 || o_occupancy !== 2'd2) begin
      errors++; $display("FAIL bp_full got r%b occ%0d exp r0 occ2", o_ready, o_occupancy); end
    drive(b2, 1'b1); tick();
    i_valid = 1'b0;
    checks++; if (o_ready !== 1'b0 || o_occupancy !== 2'd2 || o_valid !== 1'b1) begin
      errors++; $display("FAIL bp_hold got r%b occ%0d v%b exp r0 occ2 v1", o_ready, o_occupancy, o_valid); end
    exp_beat(b0.state, b0.round, b0.en, {512'b0, b0.key}, 1408, 10, est, erd, eerr);
    checks++; if (o_state !== est || o_side !== b0.side) begin
      errors++; $display("FAIL bp_first got %h exp %h", o_state, est); end
    i_ready = 1'b1;
    tick();
    exp_beat(b1.state, b1.round, b1.en, {512'b0, b1.key}, 1408, 10, est, erd, eerr);
    checks++; if (o_state !== est || o_side !== b1.side || o_phase !== b1.phase) begin
      errors++; $display("FAIL bp_second got %h exp %h", o_state, est); end
    checks++; if (o_occupancy !== 2'd1 || o_ready !== 1'b1) begin
      errors++; $display("FAIL bp_drain got occ%0d r%b exp occ1 r1", o_occupancy, o_ready); end
    tick();
    checks++; if (o_valid !== 1'b0 || o_occupancy !== 2'd0) begin
      errors++; $display("FAIL bp_nodup got v%b occ%0d exp v0 occ0", o_valid, o_occupancy); end
  endtask

  task automatic test_err_enable();
    beat_t b;
    logic [383:0] est; logic [11:0] erd; logic [2:0] eerr;
    apply_reset();
    rand_beat(b);
    b.round = {4'd3, 4'd15, 4'd5};
    b.en = 3'b011;
    drive(b, 1'b1);
    tick();
    i_valid = 1'b0;
    exp_beat(b.state, b.round, b.en, {512'b0, b.key}, 1408, 10, est, erd, eerr);
    checks++; if (o_lane_err !== 3'b010) begin errors++; $display("FAIL err_bits got %b exp 010", o_lane_err); end
    checks++; if (o_state[255:128] !== b.state[255:128]) begin errors++; $display("FAIL err_l1_state got %h exp %h", o_state[255:128], b.state[255:128]); end
    checks++; if (o_round[7:4] !== 4'd15) begin errors++; $display("FAIL err_l1_round got %0d exp 15", o_round[7:4]); end
    checks++; if (o_state[127:0] !== b.state[127:0] || o_round[3:0] !== 4'd5) begin
      errors++; $display("FAIL dis_l2 got %h/%0d exp %h/5", o_state[127:0], o_round[3:0], b.state[127:0]); end
    checks++; if (o_state[383:256] !== est[383:256] || o_round[11:8] !== 4'd4) begin
      errors++; $display("FAIL err_l0 got %h/%0d exp %h/4", o_state[383:256], o_round[11:8], est[383:256]); end
    tick();
  endtask

  task automatic test_flush();
    beat_t b;
    apply_reset();
    i_ready = 1'b0;
    rand_beat(b); drive(b, 1'b1); tick();
    rand_beat(b); drive(b, 1'b1); tick();
    checks++; if (o_occupancy !== 2'd2) begin errors++; $display("FAIL fl_pre got occ%0d exp 2", o_occupancy); end
    rand_beat(b); drive(b, 1'b1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0; i_valid = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_occupancy !== 2'd0 || o_ready !== 1'b1) begin
      errors++; $display("FAIL fl_post got v%b occ%0d r%b exp v0 occ0 r1", o_valid, o_occupancy, o_ready); end
    i_ready = 1'b1;
    tick();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL fl_drop got v%b exp 0", o_valid); end
  endtask

  task automatic test_reset_midstream();
    beat_t b;
    apply_reset();
    i_ready = 1'b0;
    rand_beat(b); drive(b, 1'b1); tick();
    rand_beat(b); drive(b, 1'b1); tick();
    i_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_occupancy !== 2'd0 || o_lane_err !== 3'b000) begin
      errors++; $display("FAIL arst got v%b r%b occ%0d e%b exp v0 r1 occ0 e000", o_valid, o_ready, o_occupancy, o_lane_err); end
    tick();
    rst = 1'b0;
    tick();
    checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_occupancy !== 2'd0) begin
      errors++; $display("FAIL arst_rel got v%b r%b occ%0d exp v0 r1 occ0", o_valid, o_ready, o_occupancy); end
    i_ready = 1'b1;
  endtask

  task automatic test_random_stream();
    beat_t q[$];
    beat_t b;
    logic [383:0] est; logic [11:0] erd; logic [2:0] eerr;
    logic v, rdy, fl, in_fire, out_fire;
    apply_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      checks++; if (o_valid !== (q.size() > 0)) begin errors++; $display("FAIL rs_valid cyc %0d got %b exp %b", cyc, o_valid, q.size() > 0); end
      checks++; if (o_ready !== (q.size() < 2)) begin errors++; $display("FAIL rs_ready cyc %0d got %b exp %b", cyc, o_ready, q.size() < 2); end
      checks++; if (o_occupancy !== 2'(q.size())) begin errors++; $display("FAIL rs_occ cyc %0d got %0d exp %0d", cyc, o_occupancy, q.size()); end
      if (q.size() > 0) begin
        exp_beat(q[0].state, q[0].round, q[0].en, {512'b0, q[0].key}, 1408, 10, est, erd, eerr);
        checks++; if (o_state !== est) begin errors++; $display("FAIL rs_state cyc %0d got %h exp %h", cyc, o_state, est); end
        checks++; if (o_round !== erd || o_lane_err !== eerr) begin
          errors++; $display("FAIL rs_round cyc %0d got %h/%b exp %h/%b", cyc, o_round, o_lane_err, erd, eerr); end
        checks++; if (o_side !== q[0].side || o_phase !== q[0].phase || o_new_instance !== q[0].ni) begin
          errors++; $display("FAIL rs_carry cyc %0d got %h/%0d/%b exp %h/%0d/%b", cyc, o_side, o_phase, o_new_instance, q[0].side, q[0].phase, q[0].ni); end
        for (int k = 0; k < 11; k++) begin
          checks++; if (o_key_schedule[128*k +: 128] !== q[0].key[128*k +: 128]) begin
            errors++; $display("FAIL rs_key cyc %0d chunk %0d got %h exp %h", cyc, k, o_key_schedule[128*k +: 128], q[0].key[128*k +: 128]); end
        end
      end
      v = ($urandom_range(0, 99) < 70);
      rdy = ($urandom_range(0, 99) < 60);
      fl = ($urandom_range(0, 99) < 3);
      rand_beat(b);
      drive(b, v);
      i_ready = rdy;
      i_flush = fl;
      in_fire = v && (q.size() < 2) && !fl;
      out_fire = (q.size() > 0) && rdy && !fl;
      tick();
      if (fl) q.delete();
      else begin
        if (out_fire) void'(q.pop_front());
        if (in_fire) q.push_back(b);
      end
    end
    i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
  endtask

  task automatic test_nr14();
    logic [383:0] st, est; logic [11:0] erd; logic [2:0] eerr;
    logic [1919:0] ks;
    apply_reset();
    for (int i = 0; i < 12; i++) st[32*i +: 32] = $urandom;
    for (int i = 0; i < 60; i++) ks[32*i +: 32] = $urandom;
    d_i_state = st; d_i_key = ks; d_i_round = {4'd14, 4'd15, 4'd13}; d_i_en = 3'b111;
    d_i_phase = 3'd5; d_i_ni = 1'b1; d_i_side = '1; d_i_ready = 1'b1; d_i_valid = 1'b1;
    tick();
    d_i_valid = 1'b0;
    exp_beat(st, d_i_round, d_i_en, ks, 1920, 14, est, erd, eerr);
    checks++; if (d_o_valid !== 1'b1) begin errors++; $display("FAIL nr14_valid got %b exp 1", d_o_valid); end
    checks++; if (d_o_state[383:256] !== ref_round(st[383:256], ks[1919-128*14 -: 128], 14, 14)) begin
      errors++; $display("FAIL nr14_final got %h exp %h", d_o_state[383:256], est[383:256]); end
    checks++; if (d_o_round !== {4'd15, 4'd15, 4'd14}) begin errors++; $display("FAIL nr14_round got %h exp ffe", d_o_round); end
    checks++; if (d_o_err !== 3'b010 || d_o_state[255:128] !== st[255:128]) begin
      errors++; $display("FAIL nr14_err got %b/%h exp 010/%h", d_o_err, d_o_state[255:128], st[255:128]); end
    checks++; if (d_o_state !== est) begin errors++; $display("FAIL nr14_lanes got %h exp %h", d_o_state, est); end
    tick();
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_back_to_back();
    test_backpressure();
    test_err_enable();
    test_flush();
    test_reset_midstream();
    test_random_stream();
    test_nr14();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
